// File: rtl/fetch_decode_buffer.sv
// Fetch-to-decode instruction buffer: DEPTH-entry FIFO between instruction memory and decode,
// with fault-aware instruction zeroing, illegal-opcode flagging and squash flush.
module fetch_decode_buffer #(
  parameter int DEPTH = 2,
  parameter int LVL_W = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              fetch_in_valid_i,
  input  logic [31:0]       fetch_in_pc_i,
  input  logic [31:0]       fetch_in_instr_i,
  input  logic              fetch_in_fault_fetch_i,
  input  logic              fetch_in_fault_page_i,
  output logic              fetch_in_accept_o,
  input  logic              squash_decode_i,
  output logic              fetch_out_valid_o,
  output logic [31:0]       fetch_out_pc_o,
  output logic [31:0]       fetch_out_instr_o,
  output logic              fetch_out_fault_fetch_o,
  output logic              fetch_out_fault_page_o,
  output logic              fetch_out_instr_invalid_o,
  input  logic              fetch_out_accept_i,
  output logic [LVL_W-1:0]  level_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [31:0]      pc_mem          [DEPTH];
  logic [31:0]      instr_mem       [DEPTH];
  logic             fault_fetch_mem [DEPTH];
  logic             fault_page_mem  [DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] count;
  logic             push, pop;

  function automatic logic is_illegal(input logic [31:0] instr);
    logic legal;
    case (instr[6:0])
      7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
      7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111, 7'b1110011: legal = 1'b1;
      default:                                                     legal = 1'b0;
    endcase
    return !(legal && (instr[1:0] == 2'b11));
  endfunction

  assign fetch_in_accept_o = (count != LVL_W'(DEPTH));
  assign fetch_out_valid_o = (count != '0);
  assign level_o           = count;

  // Squash overrides both sides of the handshake.
  assign push = fetch_in_valid_i & fetch_in_accept_o & ~squash_decode_i;
  assign pop  = fetch_out_valid_o & fetch_out_accept_i & ~squash_decode_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || squash_decode_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem[wr_ptr]          <= fetch_in_pc_i;
      instr_mem[wr_ptr]       <= (fetch_in_fault_fetch_i | fetch_in_fault_page_i) ? 32'h0
                                                                                   : fetch_in_instr_i;
      fault_fetch_mem[wr_ptr] <= fetch_in_fault_fetch_i;
      fault_page_mem[wr_ptr]  <= fetch_in_fault_page_i;
    end
  end

  always_comb begin
    fetch_out_pc_o            = '0;
    fetch_out_instr_o         = '0;
    fetch_out_fault_fetch_o   = 1'b0;
    fetch_out_fault_page_o    = 1'b0;
    fetch_out_instr_invalid_o = 1'b0;
    if (fetch_out_valid_o) begin
      fetch_out_pc_o            = pc_mem[rd_ptr];
      fetch_out_instr_o         = instr_mem[rd_ptr];
      fetch_out_fault_fetch_o   = fault_fetch_mem[rd_ptr];
      fetch_out_fault_page_o    = fault_page_mem[rd_ptr];
      fetch_out_instr_invalid_o = ~(fault_fetch_mem[rd_ptr] | fault_page_mem[rd_ptr])
                                  & is_illegal(instr_mem[rd_ptr]);
    end
  end

endmodule
